// File: rtl/conv_pkg.sv
// Shared definitions for the 2D-convolution MAC datapath.
//   - Default widths and tap count for the pixel/weight MAC.
//   - Control FSM state encoding.
//   - clog2 helper used to size the tap counter.
package conv_pkg;

    localparam int DEFAULT_PIX_W  = 8;   // pixel width, unsigned
    localparam int DEFAULT_COEF_W = 8;   // weight width, unsigned
    localparam int DEFAULT_ACC_W  = 20;  // accumulator / result width
    localparam int DEFAULT_KTAPS  = 9;   // products summed per 3x3 window

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_mult_stage.sv
// First pipeline stage of the conv MAC: registered unsigned multiplier.
// Kept as its own module so the product register can be retimed or
// absorbed into a DSP slice without touching the control logic.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high (clears product and valid)
//   in_vld    in   operands are an accepted beat this cycle
//   pixel     in   PIX_W-bit unsigned pixel
//   weight    in   COEF_W-bit unsigned coefficient
//   prod      out  registered pixel*weight
//   prod_vld  out  prod holds a product that still has to be accumulated
module conv_mult_stage
    import conv_pkg::*;
#(
    parameter int PIX_W  = DEFAULT_PIX_W,
    parameter int COEF_W = DEFAULT_COEF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [PIX_W-1:0]          pixel,
    input  logic [COEF_W-1:0]         weight,
    output logic [PIX_W+COEF_W-1:0]   prod,
    output logic                      prod_vld
);

    localparam int PROD_W = PIX_W + COEF_W;

    logic [PROD_W-1:0] prod_reg;
    logic              prod_vld_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg     <= '0;
            prod_vld_reg <= 1'b0;
        end else begin
            // in_vld already excludes aborted beats, so an abort also
            // kills the valid bit of the product it would have produced.
            prod_vld_reg <= in_vld;
            if (in_vld) begin
                prod_reg <= PROD_W'(pixel) * PROD_W'(weight);
            end
        end
    end

    assign prod     = prod_reg;
    assign prod_vld = prod_vld_reg;

endmodule

// File: rtl/conv_mac_accum.sv
// Multiply-accumulate front end of the 2D-conv datapath. Accepts one
// (pixel, weight) pair per handshake, sums KTAPS products per window and
// presents the window sum on acc_out with a one-cycle load_new_value strobe
// for the downstream result register.
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous reset, active-high
//   in_valid        in   pixel/weight pair valid
//   in_ready        out  pair accepted this cycle if in_valid (state-only)
//   pixel           in   window pixel, unsigned
//   weight          in   kernel coefficient, unsigned
//   abort           in   discard the window in progress, no strobe
//   acc_out         out  window sum (accumulator value)
//   load_new_value  out  1-cycle strobe: acc_out is a complete window sum
//   busy            out  window in progress (ACCUM, DRAIN or DONE)
module conv_mac_accum
    import conv_pkg::*;
#(
    parameter int PIX_W  = DEFAULT_PIX_W,
    parameter int COEF_W = DEFAULT_COEF_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int KTAPS  = DEFAULT_KTAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  pixel,
    input  logic [COEF_W-1:0] weight,
    input  logic              abort,
    output logic [ACC_W-1:0]  acc_out,
    output logic              load_new_value,
    output logic              busy
);

    localparam int PROD_W = PIX_W + COEF_W;
    // Counter must reach KTAPS itself (value after the last accept).
    localparam int CNT_W  = clog2(KTAPS + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   tap_cnt_reg, tap_cnt_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;

    logic               accept;
    logic [PROD_W-1:0]  prod;
    logic               prod_vld;

    // in_ready depends on state only, never on in_valid or abort.
    assign in_ready = (state_reg == IDLE) || (state_reg == ACCUM);
    // abort wins over a beat presented in the same cycle.
    assign accept   = in_valid && in_ready && !abort;

    conv_mult_stage #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (accept),
        .pixel    (pixel),
        .weight   (weight),
        .prod     (prod),
        .prod_vld (prod_vld)
    );

    always_comb begin
        state_next   = state_reg;
        tap_cnt_next = tap_cnt_reg;
        acc_next     = acc_reg;

        // S2: fold in the product registered last cycle.
        if (prod_vld) begin
            acc_next = acc_reg + ACC_W'(prod);
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // No product is pending in IDLE, so clearing here
                    // cannot lose data from the previous window.
                    acc_next     = '0;
                    tap_cnt_next = CNT_W'(1);
                    state_next   = (KTAPS == 1) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    tap_cnt_next = tap_cnt_reg + CNT_W'(1);
                    if (tap_cnt_reg == CNT_W'(KTAPS - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last product lands in acc on the cycle prod_vld is
                // high; once it drops, acc is the full window sum.
                if (!prod_vld) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next   = IDLE;
                tap_cnt_next = '0;
            end
            default: begin
                state_next   = IDLE;
                tap_cnt_next = '0;
            end
        endcase

        if (abort) begin
            state_next   = IDLE;
            tap_cnt_next = '0;
            acc_next     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tap_cnt_reg <= '0;
            acc_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            tap_cnt_reg <= tap_cnt_next;
            acc_reg     <= acc_next;
        end
    end

    assign acc_out        = acc_reg;
    assign load_new_value = (state_reg == DONE);
    assign busy           = (state_reg != IDLE);

endmodule
